// File: rtl/shared_bus_tdm_mux_pkg.sv
// Shared constants, flatten-width helpers and the round-robin owner search
// used by the TDM bus multiplexer and its slot scheduler.
package shared_bus_tdm_mux_pkg;

  localparam int MAX_CPU = 4;
  localparam int SEL_W   = 2;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic int flat_w(input int n, input int w);
    return n * w;
  endfunction

  function automatic int phase_end(input int phases);
    return phases - 1;
  endfunction

  // Closest enabled master strictly after cur, wrapping; cur itself is the
  // last candidate. idx stays at cur when nothing is enabled.
  function automatic pick_t next_enabled(input logic [MAX_CPU-1:0] en,
                                         input logic [SEL_W-1:0]   cur,
                                         input int                 ncpu);
    pick_t            p;
    int               idx;
    logic [SEL_W-1:0] i2;
    p       = '0;
    p.idx   = cur;
    for (int d = ncpu; d >= 1; d--) begin
      idx = (int'(cur) + d) % ncpu;
      i2  = SEL_W'(idx);
      if (en[i2]) begin
        p.found = 1'b1;
        p.idx   = i2;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/shared_bus_tdm_mux_sched.sv
// Slot scheduler: free-running phase counter, slot owner selection and BUSY.
// The owner is only re-chosen at the last phase of a slot.
module tdm_slot_sched
  import shared_bus_tdm_mux_pkg::*;
#(
  parameter  int NCPU   = 2,
  parameter  int PHASES = 4,
  localparam int PW     = $clog2(PHASES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCPU-1:0]  sloten,
  output logic [PW-1:0]    phase,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             slot_end
);

  logic [PW-1:0]      phase_q;
  logic [SEL_W-1:0]   sel_q;
  logic               busy_q;
  logic               fresh_q;
  logic [MAX_CPU-1:0] en;
  pick_t              first_pick;
  pick_t              next_pick;
  logic [SEL_W-1:0]   sel_now;
  logic               busy_now;

  assign en         = MAX_CPU'(sloten);
  assign first_pick = next_enabled(en, SEL_W'(NCPU - 1), NCPU);
  assign slot_end   = (phase_q == PW'(phase_end(PHASES)));

  // The first slot after reset takes its owner straight from SLOTEN.
  always_comb begin
    sel_now  = sel_q;
    busy_now = busy_q;
    if (fresh_q && !rst) begin
      busy_now = first_pick.found;
      if (first_pick.found) sel_now = first_pick.idx;
    end
  end

  assign next_pick = next_enabled(en, sel_now, NCPU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      fresh_q <= 1'b0;
      phase_q <= slot_end ? '0 : phase_q + 1'b1;
      if (slot_end) begin
        busy_q <= next_pick.found;
        sel_q  <= next_pick.found ? next_pick.idx : sel_now;
      end else begin
        busy_q <= busy_now;
        sel_q  <= sel_now;
      end
    end
  end

  assign phase = phase_q;
  assign sel   = sel_now;
  assign busy  = busy_now;

endmodule

// File: rtl/shared_bus_tdm_mux.sv
// Time-division multiplexer granting a shared bus to NCPU masters in fixed
// PHASES-cycle slots, with per-master read-data latches and step pulses.
module shared_bus_tdm_mux
  import shared_bus_tdm_mux_pkg::*;
#(
  parameter int NCPU   = 2,
  parameter int PHASES = 4,
  parameter int AW     = 16,
  parameter int DW     = 8
) (
  input  logic                         SHCLK,
  input  logic                         RESET,
  input  logic [NCPU-1:0]              SLOTEN,
  input  logic [flat_w(NCPU, AW)-1:0]  CPAD,
  input  logic [flat_w(NCPU, DW)-1:0]  CPOD,
  input  logic [NCPU-1:0]              CPRD,
  input  logic [NCPU-1:0]              CPWR,
  output logic [flat_w(NCPU, DW)-1:0]  CPID,
  output logic [NCPU-1:0]              CPCE,
  output logic [AW-1:0]                CPADR,
  output logic [DW-1:0]                CPODT,
  input  logic [DW-1:0]                CPIDT,
  output logic                         CPRED,
  output logic                         CPWRT,
  output logic [1:0]                   CPSEL,
  output logic                         BUSY
);

  localparam int PW = $clog2(PHASES);

  logic [PW-1:0]    phase;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             slot_end;
  logic             write_window;
  logic [DW-1:0]    rd_lat [NCPU];

  tdm_slot_sched #(
    .NCPU   (NCPU),
    .PHASES (PHASES)
  ) u_sched (
    .clk      (SHCLK),
    .rst      (RESET),
    .sloten   (SLOTEN),
    .phase    (phase),
    .sel      (sel),
    .busy     (busy),
    .slot_end (slot_end)
  );

  // Phase 0 is address setup and the last phase is hold.
  assign write_window = (phase != '0) && !slot_end;

  always_comb begin
    CPADR = '0;
    CPODT = '0;
    CPRED = 1'b0;
    CPWRT = 1'b0;
    CPCE  = '0;
    for (int n = 0; n < NCPU; n++) begin
      if (busy && sel == SEL_W'(n)) begin
        CPADR   = CPAD[n*AW +: AW];
        CPODT   = CPOD[n*DW +: DW];
        CPRED   = CPRD[n];
        CPWRT   = CPWR[n] && write_window;
        CPCE[n] = slot_end;
      end
    end
  end

  always_comb begin
    CPID = '0;
    for (int n = 0; n < NCPU; n++) begin
      if (busy && sel == SEL_W'(n)) CPID[n*DW +: DW] = CPIDT;
      else                          CPID[n*DW +: DW] = rd_lat[n];
    end
  end

  always_ff @(posedge SHCLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < NCPU; n++) rd_lat[n] <= '1;
    end else if (busy && slot_end) begin
      for (int n = 0; n < NCPU; n++)
        if (sel == SEL_W'(n)) rd_lat[n] <= CPIDT;
    end
  end

  assign CPSEL = sel;
  assign BUSY  = busy;

endmodule

// File: tb/tb_shared_bus_tdm_mux.sv
// Directed and model-checked bench for shared_bus_tdm_mux: a 4-master/4-phase
// instance for scheduling and data path, a 2-master/8-phase one for write timing.
module tb_shared_bus_tdm_mux;

  logic shclk = 1'b0;
  logic rst   = 1'b1;
  always #5 shclk = ~shclk;

  // Instance A: NCPU=4, PHASES=4
  logic [3:0]  sloten_a, cprd_a, cpwr_a, cpce_a;
  logic [63:0] cpad_a;
  logic [31:0] cpod_a, cpid_a;
  logic [15:0] cpadr_a;
  logic [7:0]  cpodt_a, cpidt_a;
  logic        cpred_a, cpwrt_a, busy_a;
  logic [1:0]  cpsel_a;

  // Instance B: NCPU=2, PHASES=8
  logic [1:0]  sloten_b, cprd_b, cpwr_b, cpce_b, cpsel_b;
  logic [31:0] cpad_b;
  logic [15:0] cpod_b, cpid_b;
  logic [15:0] cpadr_b;
  logic [7:0]  cpodt_b, cpidt_b;
  logic        cpred_b, cpwrt_b, busy_b;

  shared_bus_tdm_mux #(.NCPU(4), .PHASES(4), .AW(16), .DW(8)) u_dut_a (
    .SHCLK(shclk), .RESET(rst), .SLOTEN(sloten_a), .CPAD(cpad_a), .CPOD(cpod_a),
    .CPRD(cprd_a), .CPWR(cpwr_a), .CPID(cpid_a), .CPCE(cpce_a), .CPADR(cpadr_a),
    .CPODT(cpodt_a), .CPIDT(cpidt_a), .CPRED(cpred_a), .CPWRT(cpwrt_a),
    .CPSEL(cpsel_a), .BUSY(busy_a)
  );

  shared_bus_tdm_mux #(.NCPU(2), .PHASES(8), .AW(16), .DW(8)) u_dut_b (
    .SHCLK(shclk), .RESET(rst), .SLOTEN(sloten_b), .CPAD(cpad_b), .CPOD(cpod_b),
    .CPRD(cprd_b), .CPWR(cpwr_b), .CPID(cpid_b), .CPCE(cpce_b), .CPADR(cpadr_b),
    .CPODT(cpodt_b), .CPIDT(cpidt_b), .CPRED(cpred_b), .CPWRT(cpwrt_b),
    .CPSEL(cpsel_b), .BUSY(busy_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] sloten;
    logic [3:0] cprd;
    logic [3:0] cpwr;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] ce;
    logic       red;
    logic       wrt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge shclk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge shclk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] adr_of(input logic [1:0] n);
    return 16'hA000 + 16'h0111 * {14'd0, n};
  endfunction

  function automatic logic [7:0] dat_of(input logic [1:0] n);
    return 8'h30 + {6'd0, n};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] e_sel, m_sel, m_phase, idx;
    logic       e_busy, m_busy, m_fresh, found;
    logic [3:0] e_ce;
    logic [7:0] m_lat [4];
    logic [31:0] e_cpid;
    int cnt_dut [4];
    int cnt_mod [4];
    int ce1_seen, ce0_first, ce0_second, wr_cnt;

    // Constant per-master address/data patterns
    for (int n = 0; n < 4; n++) begin
      cpad_a[n*16 +: 16] = adr_of(2'(n));
      cpod_a[n*8 +: 8]   = dat_of(2'(n));
    end
    for (int n = 0; n < 2; n++) begin
      cpad_b[n*16 +: 16] = adr_of(2'(n));
      cpod_b[n*8 +: 8]   = dat_of(2'(n));
    end
    sloten_b = 2'b00; cprd_b = 2'b00; cpwr_b = 2'b00; cpidt_b = 8'h00;

    // sloten, cprd, cpwr | sel, busy, ce, red, wrt  (masters 0 and 1 enabled)
    tbl[0] = '{4'b0011, 4'b0001, 4'b0010, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[1] = '{4'b0011, 4'b0001, 4'b0010, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{4'b0011, 4'b0001, 4'b0010, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[3] = '{4'b0011, 4'b0001, 4'b0010, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[4] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[5] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[6] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[7] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0};

    // Reset state
    sloten_a = 4'b0011; cprd_a = 4'b1111; cpwr_a = 4'b1111; cpidt_a = 8'hA5;
    sloten_b = 2'b11;   cprd_b = 2'b11;   cpwr_b = 2'b11;
    @(negedge shclk);
    check("rst_ctl_a", {cpsel_a, busy_a, cpce_a, cpred_a, cpwrt_a}, 9'd0);
    check("rst_cpid_a", cpid_a, 32'hFFFF_FFFF);
    check("rst_ctl_b", {cpsel_b, busy_b, cpce_b, cpred_b, cpwrt_b}, 7'd0);
    check("rst_cpid_b", cpid_b, 16'hFFFF);

    // Two-master alternation, table driven
    sloten_a = tbl[0].sloten; cprd_a = tbl[0].cprd; cpwr_a = tbl[0].cpwr;
    sloten_b = 2'b00; cprd_b = 2'b00; cpwr_b = 2'b00;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      sloten_a = tbl[c % 8].sloten; cprd_a = tbl[c % 8].cprd; cpwr_a = tbl[c % 8].cpwr;
      @(negedge shclk);
      check($sformatf("tbl_sel_%0d", c),  cpsel_a, tbl[c % 8].sel);
      check($sformatf("tbl_busy_%0d", c), busy_a,  tbl[c % 8].busy);
      check($sformatf("tbl_ce_%0d", c),   cpce_a,  tbl[c % 8].ce);
      check($sformatf("tbl_red_%0d", c),  cpred_a, tbl[c % 8].red);
      check($sformatf("tbl_wrt_%0d", c),  cpwrt_a, tbl[c % 8].wrt);
      check($sformatf("tbl_adr_%0d", c),  cpadr_a, adr_of(tbl[c % 8].sel));
      check($sformatf("tbl_odt_%0d", c),  cpodt_a, dat_of(tbl[c % 8].sel));
      cyc();
    end
    @(negedge shclk);
    check("latch_m1_a5", cpid_a[15:8],  8'hA5);
    check("latch_m2_ff", cpid_a[23:16], 8'hFF);
    check("latch_m3_ff", cpid_a[31:24], 8'hFF);
    repeat (4) cyc();
    cpidt_a = 8'h5A;
    @(negedge shclk);
    check("latch_m0_a5", cpid_a[7:0],  8'hA5);
    check("pass_m1_5a",  cpid_a[15:8], 8'h5A);
    cyc();

    // Masters 0 and 2 enabled: sequence 0,2,0,2, round of 8 cycles
    sloten_a = 4'b0101; cprd_a = 4'b0000; cpwr_a = 4'b0000; cpidt_a = 8'hA5;
    apply_reset();
    ce1_seen = 0; ce0_first = -1; ce0_second = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge shclk);
      if (c % 4 == 0) check($sformatf("skip_sel_%0d", c), cpsel_a, ((c / 4) % 2 == 1) ? 2'd2 : 2'd0);
      check($sformatf("skip_busy_%0d", c), busy_a, 1'b1);
      if (cpce_a[1]) ce1_seen++;
      if (cpce_a[0]) begin
        if (ce0_first < 0) ce0_first = c;
        else if (ce0_second < 0) ce0_second = c;
      end
      cyc();
    end
    check("skip_ce1_never", ce1_seen, 0);
    check("skip_ce0_first", ce0_first, 3);
    check("skip_round_len", ce0_second - ce0_first, 8);

    // Clearing SLOTEN mid-slot: slot completes, then idle with CPSEL held
    sloten_a = 4'b0011; cprd_a = 4'b1111; cpwr_a = 4'b1111;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 5) sloten_a = 4'b0000;
      @(negedge shclk);
      if (c >= 5 && c <= 7) check($sformatf("clr_owner_%0d", c), {busy_a, cpsel_a}, {1'b1, 2'd1});
      if (c == 7) check("clr_last_ce", cpce_a, 4'b0010);
      if (c >= 8) check($sformatf("clr_idle_%0d", c),
                        {cpsel_a, busy_a, cpce_a, cpred_a, cpwrt_a}, {2'd1, 1'b0, 4'b0000, 1'b0, 1'b0});
      cyc();
    end

    // Reset pulsed at phase 2 of slot 1
    sloten_a = 4'b0011; cprd_a = 4'b0000; cpwr_a = 4'b1111; cpidt_a = 8'h3C;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge shclk);
      cyc();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge shclk);
      check($sformatf("midrst_ctl_%0d", c), {busy_a, cpce_a, cpwrt_a}, 6'd0);
      check($sformatf("midrst_cpid_%0d", c), cpid_a, 32'hFFFF_FFFF);
      cyc();
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge shclk);
      check($sformatf("restart_owner_%0d", c), {busy_a, cpsel_a}, {1'b1, 2'd0});
      check($sformatf("restart_wrt_%0d", c), cpwrt_a, (c == 1 || c == 2) ? 1'b1 : 1'b0);
      check($sformatf("restart_ce_%0d", c), cpce_a, (c == 3) ? 4'b0001 : 4'b0000);
      if (c == 0) check("restart_m1_ff", cpid_a[15:8], 8'hFF);
      cyc();
    end

    // Eight-phase instance: write window is phases 1..6 only
    sloten_b = 2'b01; cprd_b = 2'b01; cpwr_b = 2'b11; cpidt_b = 8'h77;
    apply_reset();
    wr_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge shclk);
      check($sformatf("p8_wrt_%0d", c), cpwrt_b, (c % 8 >= 1 && c % 8 <= 6) ? 1'b1 : 1'b0);
      check($sformatf("p8_ce_%0d", c), {cpsel_b, cpce_b}, {2'd0, (c % 8 == 7) ? 2'b01 : 2'b00});
      if (cpwrt_b) wr_cnt++;
      cyc();
    end
    check("p8_wr_cycles", wr_cnt, 12);
    sloten_b = 2'b00; cprd_b = 2'b00; cpwr_b = 2'b00;

    // Random SLOTEN/requests on the 4-master instance against a reference model
    sloten_a = 4'($urandom_range(0, 15));
    apply_reset();
    m_phase = 2'd0; m_sel = 2'd0; m_busy = 1'b0; m_fresh = 1'b1;
    for (int n = 0; n < 4; n++) begin
      m_lat[n] = 8'hFF; cnt_dut[n] = 0; cnt_mod[n] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      cprd_a  = 4'($urandom_range(0, 15));
      cpwr_a  = 4'($urandom_range(0, 15));
      cpidt_a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) sloten_a = 4'($urandom_range(0, 15));
      @(negedge shclk);
      e_busy = m_busy; e_sel = m_sel;
      if (m_fresh) begin
        e_busy = 1'b0;
        for (int i = 3; i >= 0; i--)
          if (sloten_a[2'(i)]) begin e_busy = 1'b1; e_sel = 2'(i); end
      end
      e_ce = (e_busy && m_phase == 2'd3) ? (4'b0001 << e_sel) : 4'b0000;
      for (int n = 0; n < 4; n++)
        e_cpid[n*8 +: 8] = (e_busy && e_sel == 2'(n)) ? cpidt_a : m_lat[n];
      check("rand_ctl", {cpsel_a, busy_a, cpce_a, cpred_a, cpwrt_a},
            {e_sel, e_busy, e_ce, e_busy & cprd_a[e_sel],
             e_busy & cpwr_a[e_sel] & (m_phase == 2'd1 || m_phase == 2'd2)});
      check("rand_cpid", cpid_a, e_cpid);
      check("rand_onehot", $onehot0(cpce_a), 1'b1);
      if (e_busy) check("rand_bus", {cpadr_a, cpodt_a}, {adr_of(e_sel), dat_of(e_sel)});
      for (int n = 0; n < 4; n++) if (cpce_a[n]) cnt_dut[n]++;
      if (e_ce != 4'b0000) cnt_mod[e_sel]++;
      // Advance the reference scheduler to the next cycle
      if (m_phase == 2'd3) begin
        if (e_busy) m_lat[e_sel] = cpidt_a;
        found = 1'b0;
        for (int d = 1; d <= 4; d++) begin
          idx = e_sel + 2'(d);
          if (sloten_a[idx]) begin found = 1'b1; break; end
        end
        m_busy = found;
        m_sel  = found ? idx : e_sel;
      end else begin
        m_busy = e_busy;
        m_sel  = e_sel;
      end
      m_fresh = 1'b0;
      m_phase = m_phase + 2'd1;
      cyc();
    end
    for (int n = 0; n < 4; n++)
      check($sformatf("rand_pulses_m%0d", n), cnt_dut[n], cnt_mod[n]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_bus_tdm_mux.md
SHARED_BUS_TDM_MUX -- requirements
Module: shared_bus_tdm_mux

Interface
REQ-001 Parameter NCPU, default 2: number of bus masters, legal range 2..4.
REQ-002 Parameter PHASES, default 4: SHCLK cycles per slot, a power of two in the range 4..16.
REQ-003 Parameters AW and DW, defaults 16 and 8: address width and data width.
REQ-004 SHCLK  in  1: the single clock; all logic runs on its rising edge.
REQ-005 RESET  in  1: asynchronous, active-high reset.
REQ-006 SLOTEN  in  NCPU: per-master slot enable, sampled only at slot boundaries.
REQ-007 CPAD  in  NCPU*AW: flattened master addresses; master n occupies bits [n*AW +: AW].
REQ-008 CPOD  in  NCPU*DW: flattened master write data.
REQ-009 CPRD and CPWR  in  NCPU each: per-master read request and write request.
REQ-010 CPID  out  NCPU*DW: flattened per-master read data.
REQ-011 CPCE  out  NCPU: per-master one-cycle clock-enable pulse that advances that master by one step.
REQ-012 CPADR, CPODT  out  AW, DW: shared bus address and write data.
REQ-013 CPIDT  in  DW: shared bus read data.
REQ-014 CPRED, CPWRT  out  1 each: shared bus read strobe and write strobe.
REQ-015 CPSEL  out  2: index of the current slot owner.
REQ-016 BUSY  out  1: high while a slot is owned by an enabled master.

Function
REQ-017 A phase counter counts 0..PHASES-1 and wraps; a slot ends when the phase counter is at PHASES-1.
REQ-018 At the end of a slot, the next owner is the lowest-distance enabled master after the current owner, searching upward with wrap-around; the current owner may be selected again if it is the only enabled master.
REQ-019 If SLOTEN is all zero at a slot boundary, CPSEL holds its value, BUSY=0, CPRED=CPWRT=0, no CPCE pulses occur, and the phase counter keeps running.
REQ-020 While BUSY=1, CPADR, CPODT and CPRED come combinationally from master CPSEL.
REQ-021 CPWRT equals CPWR[CPSEL] only in phases 1..PHASES-2; it is 0 in phase 0 (address setup) and in phase PHASES-1 (hold), giving exactly one write window per slot.
REQ-022 In phase PHASES-1 of a busy slot, CPIDT is registered into the per-master latch of CPSEL, and CPCE[CPSEL] is high for that one cycle only.
REQ-023 CPID for master CPSEL passes CPIDT through while BUSY=1; every other master sees its latch value.
REQ-024 At most one CPCE bit is high in any cycle; each enabled master receives exactly one CPCE pulse per slot it owns.
REQ-025 A change to SLOTEN in mid-slot does not affect the current slot; clearing the owner's bit mid-slot still completes that slot, including its latch and CPCE pulse.
REQ-026 Slot round length equals PHASES multiplied by the number of enabled masters; there is no idle gap between consecutive busy slots.

Reset
REQ-027 While RESET=1: phase=0, CPSEL=0, BUSY=0, CPCE=0, CPRED=0, CPWRT=0, and all read latches = all-ones.
REQ-028 On release of RESET, the first slot goes to the lowest enabled master at phase 0; if none is enabled, REQ-019 applies.
REQ-029 Asserting RESET mid-slot aborts the slot immediately, with no CPCE pulse and no latch update.

Structure
REQ-030 The flatten/slice helper widths, the phase-end constant, and the next-enabled-index function are placed in a shared package.
REQ-031 The module contains one sub-module, tdm_slot_sched, which holds the phase counter, the owner selection, and BUSY; the data path stays in the top level.

Verification
REQ-032 NCPU=2, PHASES=4, SLOTEN=11, bus returning CPIDT=A5 -> CPCE alternates 01/10 every 4 cycles, and each CPID latch reads A5.
REQ-033 NCPU=3, SLOTEN=101 -> CPSEL sequence 0,2,0,2; CPCE[1] is never high; round length is 8 cycles.
REQ-034 CPWR[0]=1 held for the whole slot with PHASES=8 -> CPWRT is high for exactly cycles 1..6 of the slot, giving one write per slot.
REQ-035 SLOTEN changed from 11 to 00 mid-slot -> the current slot completes with its CPCE pulse; then BUSY=0, strobes are 0, and CPSEL holds.
REQ-036 RESET pulsed at phase 2 of slot 1 -> no CPCE pulse, latches read FF, and the slot restarts at master 0, phase 0.
REQ-037 NCPU=4 random SLOTEN and requests, checked against a reference scheduler model -> CPCE is one-hot or zero in every cycle, and per-master pulse counts match the model.
